// File: rtl/memory_stage_if.sv
// memory_stage_if: execute-side, writeback-side and data-memory signals of the memory stage
interface memory_stage_if;
  logic        ex_valid;
  logic        ex_memRead;
  logic        ex_memWrite;
  logic        ex_halt;
  logic [15:0] ex_addr;
  logic [15:0] ex_wdata;
  logic        stall;
  logic [15:0] mem_out;
  logic        wb_valid;
  logic        err;
  logic        createdump;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_rd;
  logic        dm_wr;
  logic [15:0] dm_rdata;
  logic        dm_busy;
  logic        dm_done;
  modport slave (
    input  ex_valid, ex_memRead, ex_memWrite, ex_halt, ex_addr, ex_wdata, dm_rdata, dm_busy, dm_done,
    output stall, mem_out, wb_valid, err, createdump, dm_addr, dm_wdata, dm_rd, dm_wr
  );
  modport master (
    output ex_valid, ex_memRead, ex_memWrite, ex_halt, ex_addr, ex_wdata, dm_rdata, dm_busy, dm_done,
    input  stall, mem_out, wb_valid, err, createdump, dm_addr, dm_wdata, dm_rd, dm_wr
  );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: pipeline memory stage sequencing one data-memory access at a time,
// with alignment/timeout fault detection and a halt that freezes further acceptance.
module memory_stage #(
  parameter int MAX_WAIT = 8
) (
  input logic clk,
  input logic rst,
  memory_stage_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int CW = $clog2(MAX_WAIT + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic is_rd, halted;
  logic acc, good, bad, done, timeout;
  always_comb begin
    acc = state == IDLE && bus.ex_valid && !halted;
    bad = acc && !bus.ex_halt && (bus.ex_memRead || bus.ex_memWrite) &&
          (bus.ex_addr[0] || (bus.ex_memRead && bus.ex_memWrite));
    good = acc && !bus.ex_halt && (bus.ex_memRead || bus.ex_memWrite) && !bad;
    done = state == WAIT && bus.dm_done;
    timeout = state == WAIT && !bus.dm_done && cnt == CW'(MAX_WAIT - 1);
    state_nx = good ? ISSUE :
               (state == ISSUE && !bus.dm_busy) ? WAIT :
               (done || timeout) ? RESP :
               state == RESP ? IDLE : state;
  end
  assign bus.stall = state != IDLE;
  assign bus.dm_rd = state == ISSUE && is_rd;
  assign bus.dm_wr = state == ISSUE && !is_rd;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      is_rd <= 1'b0;
      halted <= 1'b0;
      bus.mem_out <= 16'h0000;
      bus.dm_addr <= 16'h0000;
      bus.dm_wdata <= 16'h0000;
      bus.wb_valid <= 1'b0;
      bus.err <= 1'b0;
      bus.createdump <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= state == ISSUE ? '0 : state == WAIT ? cnt + CW'(1) : cnt;
      halted <= halted || (acc && bus.ex_halt);
      // faulted and non-memory instructions retire straight from IDLE
      bus.wb_valid <= (acc && !bus.ex_halt && !good) || done || timeout;
      bus.createdump <= acc && bus.ex_halt;
      bus.err <= bus.err || bad || timeout;
      if (good) begin
        bus.dm_addr <= bus.ex_addr;
        bus.dm_wdata <= bus.ex_wdata;
        is_rd <= bus.ex_memRead;
      end
      if (done && is_rd) bus.mem_out <= bus.dm_rdata;
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed stimulus with a writeback scoreboard and a scripted data-memory responder
module tb_memory_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  memory_stage_if bus();
  memory_stage #(.MAX_WAIT(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {logic [15:0] m; logic e;} exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int busy_n = 0;
  int done_n = 0;
  logic [15:0] rdata_v = 16'h0000;
  int rd_cycles = 0;
  int wr_cycles = 0;
  logic [15:0] last_addr = 16'h0000;
  logic [15:0] last_wdata = 16'h0000;

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  // data memory: busy for busy_n request cycles, then done on WAIT cycle done_n (-1 = never)
  initial begin
    int busy_cnt = 0;
    int wait_cnt = 0;
    bit armed = 0;
    bus.dm_busy = 1'b0;
    bus.dm_done = 1'b0;
    bus.dm_rdata = 16'hDEAD;
    forever begin
      @(negedge clk);
      bus.dm_busy = 1'b0;
      bus.dm_done = 1'b0;
      bus.dm_rdata = 16'hDEAD;
      if (bus.dm_rd || bus.dm_wr) begin
        rd_cycles += int'(bus.dm_rd);
        wr_cycles += int'(bus.dm_wr);
        last_addr = bus.dm_addr;
        last_wdata = bus.dm_wdata;
        if (busy_cnt < busy_n) begin
          bus.dm_busy = 1'b1;
          busy_cnt++;
        end else begin
          armed = 1;
          wait_cnt = 0;
        end
      end else begin
        busy_cnt = 0;
        if (armed && bus.stall) begin
          if (wait_cnt == done_n) begin
            bus.dm_done = 1'b1;
            bus.dm_rdata = rdata_v;
            armed = 0;
          end
          wait_cnt++;
        end else armed = 0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.wb_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wb_unexpected actual=wb_valid required=no_pulse t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("wb_mem_out", bus.mem_out, e.m);
          chk("wb_err", 16'(bus.err), 16'(e.e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic rd, input logic wr, input logic hlt, input logic [15:0] a, input logic [15:0] d);
    bus.ex_valid = 1'b1;
    bus.ex_memRead = rd;
    bus.ex_memWrite = wr;
    bus.ex_halt = hlt;
    bus.ex_addr = a;
    bus.ex_wdata = d;
    @(negedge clk);
    bus.ex_valid = 1'b0;
    bus.ex_memRead = 1'b0;
    bus.ex_memWrite = 1'b0;
    bus.ex_halt = 1'b0;
    bus.ex_addr = 16'h0000;
    bus.ex_wdata = 16'h0000;
  endtask

  task automatic stall_chk(input string n, input int want);
    int k = 0;
    while (bus.stall && k < 40) begin
      k++;
      @(negedge clk);
    end
    chk(n, 16'(k), 16'(want));
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic abort(input int b, input int settle);
    busy_n = b;
    done_n = -1;
    drive(1'b1, 1'b0, 1'b0, 16'h0070, 16'h0000);
    repeat (settle) @(negedge clk);
    chk("abort_pre_stall", 16'(bus.stall), 16'h1);
    chk("abort_pre_rd", 16'(bus.dm_rd), 16'(b > 0));
    #2 rst = 1'b1;
    #1;
    chk("abort_dm_rd", 16'(bus.dm_rd), 16'h0);
    chk("abort_dm_wr", 16'(bus.dm_wr), 16'h0);
    chk("abort_stall", 16'(bus.stall), 16'h0);
    chk("abort_mem_out", bus.mem_out, 16'h0000);
    chk("abort_dm_addr", bus.dm_addr, 16'h0000);
    chk("abort_err", 16'(bus.err), 16'h0);
    chk("abort_wb_valid", 16'(bus.wb_valid), 16'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int r0, w0;
    rst = 1'b1;
    bus.ex_valid = 1'b0;
    bus.ex_memRead = 1'b0;
    bus.ex_memWrite = 1'b0;
    bus.ex_halt = 1'b0;
    bus.ex_addr = 16'h0000;
    bus.ex_wdata = 16'h0000;
    @(negedge clk);
    chk("rst_mem_out", bus.mem_out, 16'h0000);
    chk("rst_dm_addr", bus.dm_addr, 16'h0000);
    chk("rst_dm_wdata", bus.dm_wdata, 16'h0000);
    chk("rst_flags", {11'd0, bus.wb_valid, bus.err, bus.createdump, bus.dm_rd, bus.dm_wr}, 16'h0000);
    chk("rst_stall", 16'(bus.stall), 16'h0);
    rst = 1'b0;
    @(negedge clk);
    // aligned load, memory ready at once
    busy_n = 0; done_n = 0; rdata_v = 16'hBEEF;
    r0 = rd_cycles; w0 = wr_cycles;
    exp_q.push_back('{16'hBEEF, 1'b0});
    drive(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    stall_chk("load_stall", 3);
    chk("load_rd_cycles", 16'(rd_cycles - r0), 16'd1);
    chk("load_wr_cycles", 16'(wr_cycles - w0), 16'd0);
    chk("load_addr", last_addr, 16'h0010);
    chk("load_mem_out", bus.mem_out, 16'hBEEF);
    chk("load_q_empty", 16'(exp_q.size()), 16'd0);
    // store held through three busy cycles
    busy_n = 3; rdata_v = 16'hFFFF;
    r0 = rd_cycles; w0 = wr_cycles;
    exp_q.push_back('{16'hBEEF, 1'b0});
    drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'h1234);
    stall_chk("store_stall", 6);
    chk("store_wr_cycles", 16'(wr_cycles - w0), 16'd4);
    chk("store_rd_cycles", 16'(rd_cycles - r0), 16'd0);
    chk("store_addr", last_addr, 16'h0020);
    chk("store_wdata", last_wdata, 16'h1234);
    chk("store_mem_out", bus.mem_out, 16'hBEEF);
    // done on the final allowed WAIT cycle beats the timeout
    busy_n = 0; done_n = 7; rdata_v = 16'h5A5A;
    exp_q.push_back('{16'h5A5A, 1'b0});
    drive(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000);
    stall_chk("edge_done_stall", 10);
    chk("edge_done_err", 16'(bus.err), 16'h0);
    // non-memory instruction retires immediately
    exp_q.push_back('{16'h5A5A, 1'b0});
    drive(1'b0, 1'b0, 1'b0, 16'h0044, 16'h0000);
    chk("nonmem_stall", 16'(bus.stall), 16'h0);
    // timeout
    done_n = -1;
    r0 = rd_cycles;
    exp_q.push_back('{16'h5A5A, 1'b1});
    drive(1'b1, 1'b0, 1'b0, 16'h0050, 16'h0000);
    stall_chk("timeout_stall", 10);
    chk("timeout_err", 16'(bus.err), 16'h1);
    chk("timeout_mem_out", bus.mem_out, 16'h5A5A);
    chk("timeout_rd_cycles", 16'(rd_cycles - r0), 16'd1);
    // sticky err, later load still served
    done_n = 1; rdata_v = 16'h1111;
    exp_q.push_back('{16'h1111, 1'b1});
    drive(1'b1, 1'b0, 1'b0, 16'h0060, 16'h0000);
    stall_chk("sticky_stall", 4);
    chk("sticky_mem_out", bus.mem_out, 16'h1111);
    // asynchronous reset during ISSUE and during WAIT
    abort(9, 0);
    abort(0, 1);
    busy_n = 0; done_n = 0; rdata_v = 16'h2222;
    exp_q.push_back('{16'h2222, 1'b0});
    drive(1'b1, 1'b0, 1'b0, 16'h0080, 16'h0000);
    stall_chk("post_rst_stall", 3);
    chk("post_rst_mem_out", bus.mem_out, 16'h2222);
    chk("post_rst_err", 16'(bus.err), 16'h0);
    // misaligned load
    r0 = rd_cycles;
    exp_q.push_back('{16'h2222, 1'b1});
    drive(1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000);
    chk("misalign_stall", 16'(bus.stall), 16'h0);
    @(negedge clk);
    chk("misalign_rd_cycles", 16'(rd_cycles - r0), 16'd0);
    chk("misalign_err", 16'(bus.err), 16'h1);
    pulse_rst();
    // read and write together
    r0 = rd_cycles; w0 = wr_cycles;
    exp_q.push_back('{16'h0000, 1'b1});
    drive(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000);
    chk("rdwr_stall", 16'(bus.stall), 16'h0);
    @(negedge clk);
    chk("rdwr_req_cycles", 16'(rd_cycles - r0 + wr_cycles - w0), 16'd0);
    chk("rdwr_err", 16'(bus.err), 16'h1);
    pulse_rst();
    // halt with a store attached, then everything ignored
    w0 = wr_cycles; r0 = rd_cycles;
    drive(1'b0, 1'b1, 1'b1, 16'h0090, 16'h0000);
    chk("halt_dump", 16'(bus.createdump), 16'h1);
    chk("halt_stall", 16'(bus.stall), 16'h0);
    @(negedge clk);
    chk("halt_dump_off", 16'(bus.createdump), 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h00A0, 16'h0000);
    repeat (3) @(negedge clk);
    chk("halted_req_cycles", 16'(rd_cycles - r0 + wr_cycles - w0), 16'd0);
    chk("halted_stall", 16'(bus.stall), 16'h0);
    chk("halted_dump", 16'(bus.createdump), 16'h0);
    pulse_rst();
    rdata_v = 16'h3333;
    exp_q.push_back('{16'h3333, 1'b0});
    drive(1'b1, 1'b0, 1'b0, 16'h00B0, 16'h0000);
    stall_chk("unhalt_stall", 3);
    chk("unhalt_mem_out", bus.mem_out, 16'h3333);
    @(negedge clk);
    chk("final_q_empty", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
